// File: rtl/reg_scoreboard_if.sv
// Issue, writeback and hazard-query signals between decode/writeback and the register scoreboard.
interface reg_scoreboard_if #(
    parameter int CNT_W = 3
);
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic             issue_ready;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             stall;
    logic [CNT_W-1:0] pending_cnt;
    logic [31:0]      busy_vec;
    logic             err_wb;

    modport master (
        output issue_valid, issue_rd, wb_valid, wb_rd, rs1, rs2,
        input  issue_ready, stall, pending_cnt, busy_vec, err_wb
    );

    modport slave (
        input  issue_valid, issue_rd, wb_valid, wb_rd, rs1, rs2,
        output issue_ready, stall, pending_cnt, busy_vec, err_wb
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for multi-cycle units: per-register busy bits, source hazard
// stall with same-cycle writeback bypass, WAW/full issue back-pressure and a sticky stray-writeback flag.
module reg_scoreboard #(
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 3
) (
    input logic             clock,
    input logic             reset,
    reg_scoreboard_if.slave sb
);
    function automatic logic reg_eq(input logic [4:0] a, input logic [4:0] b);
        return &(a ~^ b);
    endfunction

    logic [31:0]      busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic wb_nz, wb_hit, wb_miss, wb_same_issue;
    logic clr1, clr2, full, waw, ready, accept, inc;

    always_comb begin
        wb_nz         = sb.wb_valid & (sb.wb_rd != 5'd0);
        wb_hit        = wb_nz & busy_q[sb.wb_rd];
        wb_miss       = wb_nz & ~busy_q[sb.wb_rd];
        wb_same_issue = sb.wb_valid & reg_eq(sb.wb_rd, sb.issue_rd);
        clr1          = sb.wb_valid & reg_eq(sb.wb_rd, sb.rs1);
        clr2          = sb.wb_valid & reg_eq(sb.wb_rd, sb.rs2);

        // A writeback freeing a slot or the very same register lets the issue through this cycle.
        full   = (cnt_q == CNT_W'(MAX_PENDING)) & ~wb_hit;
        waw    = busy_q[sb.issue_rd] & ~wb_same_issue;
        ready  = ~full & ~waw;
        accept = sb.issue_valid & ready;
        inc    = accept & (sb.issue_rd != 5'd0);

        // Clear before set so an issue and writeback to one register leave it pending.
        busy_d = busy_q;
        if (wb_hit) busy_d[sb.wb_rd] = 1'b0;
        if (inc)    busy_d[sb.issue_rd] = 1'b1;

        cnt_d = cnt_q;
        if (inc && !wb_hit)      cnt_d = cnt_q + CNT_W'(1);
        else if (!inc && wb_hit) cnt_d = cnt_q - CNT_W'(1);

        err_d = err_q | wb_miss;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign sb.issue_ready = ready;
    assign sb.stall       = (busy_q[sb.rs1] & (sb.rs1 != 5'd0) & ~clr1)
                          | (busy_q[sb.rs2] & (sb.rs2 != 5'd0) & ~clr2);
    assign sb.pending_cnt = cnt_q;
    assign sb.busy_vec    = busy_q;
    assign sb.err_wb      = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed bench for reg_scoreboard against a pending-list reference model.
module tb_reg_scoreboard;
    localparam int MAX_PENDING = 4;
    localparam int CNT_W       = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    reg_scoreboard_if #(.CNT_W(CNT_W)) sb ();

    reg_scoreboard #(.MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .sb    (sb.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the list of registers with an outstanding write, plus the sticky error.
    logic [4:0] pend_q[$];
    bit         m_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (pend_q[i]) if (pend_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] v = '0;
        foreach (pend_q[i]) v[pend_q[i]] = 1'b1;
        return v;
    endfunction

    task automatic step(input bit iv, input logic [4:0] ird, input bit wv, input logic [4:0] wrd,
                        input logic [4:0] r1, input logic [4:0] r2);
        bit frees, exp_ready, exp_stall;
        @(negedge clock);
        sb.issue_valid = iv; sb.issue_rd = ird;
        sb.wb_valid = wv;    sb.wb_rd = wrd;
        sb.rs1 = r1;         sb.rs2 = r2;
        #1;
        frees     = wv && m_busy(wrd);
        exp_ready = !((pend_q.size() == MAX_PENDING) && !frees) && !(m_busy(ird) && !(wv && wrd == ird));
        exp_stall = (m_busy(r1) && !(wv && wrd == r1)) || (m_busy(r2) && !(wv && wrd == r2));
        check_val("issue_ready", 32'(sb.issue_ready), 32'(exp_ready));
        check_val("stall", 32'(sb.stall), 32'(exp_stall));
        check_val("pending_cnt", 32'(sb.pending_cnt), 32'(pend_q.size()));
        check_val("busy_vec", sb.busy_vec, m_vec());
        check_val("err_wb", 32'(sb.err_wb), 32'(m_err));
        check_val("cnt_le_max", 32'(int'(sb.pending_cnt) <= MAX_PENDING), 32'd1);
        @(posedge clock);
        if (frees) begin
            for (int i = 0; i < pend_q.size(); i++)
                if (pend_q[i] == wrd) begin pend_q.delete(i); break; end
        end else if (wv && wrd != 5'd0) begin
            m_err = 1'b1;
        end
        if (iv && exp_ready && ird != 5'd0) pend_q.push_back(ird);
        #1;
    endtask

    task automatic idle_inputs();
        sb.issue_valid = 1'b0; sb.issue_rd = '0;
        sb.wb_valid = 1'b0;    sb.wb_rd = '0;
        sb.rs1 = '0;           sb.rs2 = '0;
    endtask

    // Reset asserted between edges must clear state immediately, before any clock edge.
    task automatic mid_cycle_reset();
        @(negedge clock);
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        check_val("rst_err_wb", 32'(sb.err_wb), 32'd0);
        check_val("rst_cnt", 32'(sb.pending_cnt), 32'd0);
        check_val("rst_busy", sb.busy_vec, 32'd0);
        check_val("rst_ready", 32'(sb.issue_ready), 32'd1);
        pend_q.delete();
        m_err = 1'b0;
        @(negedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        m_err = 1'b0;
        mid_cycle_reset();

        step(0, 0, 0, 0, 3, 4);

        step(1, 5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 5, 0);
        check_val("plan_busy5", sb.busy_vec, 32'h20);
        step(0, 0, 1, 5, 5, 0);
        check_val("plan_cnt_after_wb", 32'(sb.pending_cnt), 32'd0);

        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check_val("plan_rd0_err", 32'(sb.err_wb), 32'd0);

        for (int r = 1; r <= 4; r++) step(1, 5'(r), 0, 0, 0, 0);
        step(1, 6, 0, 0, 0, 0);
        check_val("plan_full_block", sb.busy_vec, 32'h1E);
        step(1, 6, 1, 2, 2, 6);
        check_val("plan_full_swap_busy", sb.busy_vec, 32'h5A);
        check_val("plan_full_swap_cnt", 32'(sb.pending_cnt), 32'd4);

        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 3, 0, 0);
        step(0, 0, 1, 4, 0, 0);
        step(0, 0, 1, 6, 0, 0);
        step(1, 7, 0, 0, 0, 0);
        step(1, 7, 0, 0, 7, 0);
        step(1, 7, 1, 7, 0, 7);
        check_val("plan_waw_busy", sb.busy_vec, 32'h80);
        check_val("plan_waw_cnt", 32'(sb.pending_cnt), 32'd1);

        step(0, 0, 1, 9, 0, 0);
        check_val("plan_err_set", 32'(sb.err_wb), 32'd1);
        step(0, 0, 0, 0, 7, 9);
        mid_cycle_reset();

        for (int n = 0; n < 600; n++) begin
            logic [4:0] ird, wrd, r1, r2;
            bit iv, wv;
            if (n % 150 == 149) mid_cycle_reset();
            iv  = ($urandom_range(0, 99) < 60);
            ird = 5'($urandom_range(0, 9));
            wv  = ($urandom_range(0, 99) < 45);
            if (pend_q.size() != 0 && $urandom_range(0, 99) < 85)
                wrd = pend_q[$urandom_range(0, pend_q.size() - 1)];
            else
                wrd = 5'($urandom_range(0, 9));
            r1 = 5'($urandom_range(0, 9));
            r2 = ($urandom_range(0, 3) == 0) ? wrd : 5'($urandom_range(0, 9));
            step(iv, ird, wv, wrd, r1, r2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
